order_msg_parser: RTL and testbench

ORDER_MSG_PARSER -- requirements
Module: order_msg_parser

---
 rtl/hft_pkg.sv | 38 +++
 rtl/order_msg_parser.sv | 162 ++++++++++++++++
 tb/tb_order_msg_parser.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hft_pkg.sv
// hft_pkg: message types, order record layout and frame geometry shared by the
// order-message parser and the bid/ask order book.
`default_nettype none

package hft_pkg;

    typedef enum logic [7:0] {
        MSG_ADD    = 8'h41,
        MSG_DELETE = 8'h44,
        MSG_UPDATE = 8'h55
    } message_type_t;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic        side;
        logic [31:0] order_id;
        logic [31:0] price;
        logic [31:0] quantity;
    } order_msg_t;

    localparam logic [7:0] C_SIDE_BUY  = 8'h42;
    localparam logic [7:0] C_SIDE_SELL = 8'h53;

    localparam int unsigned C_HEADER_LEN       = 2;
    localparam int unsigned C_FULL_FRAME_LEN   = 14;
    localparam int unsigned C_DELETE_FRAME_LEN = 6;

    function automatic logic is_known_type(input logic [7:0] b);
        return (b == MSG_ADD) || (b == MSG_DELETE) || (b == MSG_UPDATE);
    endfunction

    function automatic logic is_valid_side(input logic [7:0] b);
        return (b == C_SIDE_BUY) || (b == C_SIDE_SELL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/order_msg_parser.sv
// order_msg_parser: turns a framed byte stream of Add/Update/Delete messages
// into one order record per valid frame, counting rejected frames.
`default_nettype none

module order_msg_parser
    import hft_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output order_msg_t           out_order,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SIDE    = 3'd1,
        S_FIELD   = 3'd2,
        S_DISCARD = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    // Index of the final payload byte (payload counted after type and side).
    localparam logic [3:0] C_LAST_IDX_FULL = 4'(C_FULL_FRAME_LEN - C_HEADER_LEN - 1);
    localparam logic [3:0] C_LAST_IDX_DEL  = 4'(C_DELETE_FRAME_LEN - C_HEADER_LEN - 1);

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [3:0]             r_last_idx;
    logic [7:0]             r_type;
    logic                   r_side;
    logic [87:0]            r_shift;
    order_msg_t             r_order;
    logic                   r_out_valid;
    logic                   r_in_ready;
    logic [ERR_CNT_W-1:0]   r_err;

    logic                   w_accept;
    logic                   w_is_final;
    logic [95:0]            w_full;
    logic                   w_err_event;

    assign w_accept   = in_valid && r_in_ready;
    assign w_is_final = (r_cnt == r_last_idx);
    assign w_full     = {r_shift, in_data};

    always_comb begin
        w_err_event = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE:  w_err_event = !is_known_type(in_data) || in_last;
                S_SIDE:  w_err_event = !is_valid_side(in_data) || in_last;
                S_FIELD: w_err_event = w_is_final ? !in_last : in_last;
                default: w_err_event = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_idx  <= '0;
            r_type      <= '0;
            r_side      <= 1'b0;
            r_shift     <= '0;
            r_order     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_type  <= in_data;
                        r_last_idx <= (in_data == MSG_DELETE) ? C_LAST_IDX_DEL
                                                              : C_LAST_IDX_FULL;
                        if (!is_known_type(in_data))
                            r_state <= in_last ? S_IDLE : S_DISCARD;
                        else if (!in_last)
                            r_state <= S_SIDE;
                    end
                end
                S_SIDE: begin
                    if (w_accept) begin
                        r_side <= (in_data == C_SIDE_BUY);
                        if (!is_valid_side(in_data))
                            r_state <= in_last ? S_IDLE : S_DISCARD;
                        else
                            r_state <= in_last ? S_IDLE : S_FIELD;
                    end
                end
                S_FIELD: begin
                    if (w_accept) begin
                        r_shift <= w_full[87:0];
                        r_cnt   <= r_cnt + 4'd1;
                        if (w_is_final && in_last) begin
                            r_order.msg_type <= r_type;
                            r_order.side     <= r_side;
                            if (r_type == MSG_DELETE) begin
                                r_order.order_id <= w_full[31:0];
                                r_order.price    <= '0;
                                r_order.quantity <= '0;
                            end else begin
                                r_order.order_id <= w_full[95:64];
                                r_order.price    <= w_full[63:32];
                                r_order.quantity <= w_full[31:0];
                            end
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= S_EMIT;
                        end else if (w_is_final) begin
                            r_state <= S_DISCARD;
                        end else if (in_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_accept && in_last)
                        r_state <= S_IDLE;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Saturates rather than wrapping so a flood of bad frames stays visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_err <= '0;
        else if (w_err_event && (r_err != {ERR_CNT_W{1'b1}}))
            r_err <= r_err + 1'b1;
    end

    assign in_ready  = r_in_ready;
    assign out_order = r_order;
    assign out_valid = r_out_valid;
    assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_order_msg_parser.sv
// tb_order_msg_parser: directed scenario tests for order_msg_parser with a
// narrow error counter so saturation is reachable.
`default_nettype none

module tb_order_msg_parser;
    import hft_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    order_msg_t  out_order;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  err_count;

    int tests = 0;
    int fails = 0;
    int n_tx  = 0;
    order_msg_t last_tx;

    logic [7:0] fb [0:15];
    int         flen;

    order_msg_parser #(.ERR_CNT_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_order(out_order),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            n_tx    = n_tx + 1;
            last_tx = out_order;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            tests++; fails++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic build_frame(input logic [7:0] t, input logic [7:0] s,
                               input logic [31:0] id, input logic [31:0] p,
                               input logic [31:0] q);
        fb[0] = t;  fb[1] = s;
        fb[2] = id[31:24]; fb[3] = id[23:16]; fb[4] = id[15:8]; fb[5] = id[7:0];
        fb[6] = p[31:24];  fb[7] = p[23:16];  fb[8] = p[15:8];  fb[9] = p[7:0];
        fb[10] = q[31:24]; fb[11] = q[23:16]; fb[12] = q[15:8]; fb[13] = q[7:0];
        flen = (t == 8'h44) ? 6 : 14;
    endtask

    // Sends the first n_send bytes of fb, raising in_last on index last_idx.
    task automatic send_frame(input int last_idx, input int n_send, input bit gap);
        for (int i = 0; i < n_send; i++) begin
            send_byte(fb[i], (i == last_idx));
            if (gap && i != n_send - 1) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_last = 0; in_data = 0; out_ready = 1;
        do_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_order !== 105'd0) begin fails++; $display("FAIL reset_out_order: got %h want 0", out_order); end
        tests++; if (err_count !== 4'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", err_count); end
    endtask

    task automatic test_add();
        int tx0 = n_tx;
        build_frame(8'h41, 8'h42, 32'd7, 32'd100, 32'd10);
        send_frame(13, 14, 0);
        tests++; if (out_valid !== 1'b1 || out_order !== {8'h41, 1'b1, 32'd7, 32'd100, 32'd10}) begin
            fails++; $display("FAIL add_out: valid=%b order=%h", out_valid, out_order); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL add_in_ready_emit: got %b want 0", in_ready); end
        @(posedge clk); #1;
        tests++; if (n_tx - tx0 !== 1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL add_tx_count: got %0d want 1 (valid=%b)", n_tx - tx0, out_valid); end
        tests++; if (err_count !== 4'd0) begin fails++; $display("FAIL add_err: got %0d want 0", err_count); end
    endtask

    task automatic test_delete_gapped();
        int tx0 = n_tx;
        build_frame(8'h44, 8'h53, 32'd7, 32'd0, 32'd0);
        send_frame(5, 6, 1);
        tests++; if (out_valid !== 1'b1 || out_order !== {8'h44, 1'b0, 32'd7, 32'd0, 32'd0}) begin
            fails++; $display("FAIL delete_out: valid=%b order=%h", out_valid, out_order); end
        @(posedge clk); #1;
        tests++; if (n_tx - tx0 !== 1 || err_count !== 4'd0) begin
            fails++; $display("FAIL delete_tx_err: tx=%0d err=%0d want 1,0", n_tx - tx0, err_count); end
    endtask

    task automatic test_unknown_type();
        int tx0 = n_tx;
        fb[0] = 8'h5A; fb[1] = 8'h53; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h07;
        send_frame(5, 6, 0);
        build_frame(8'h41, 8'h53, 32'd9, 32'd200, 32'd3);
        send_frame(13, 14, 0);
        @(posedge clk); #1;
        tests++; if (err_count !== 4'd1) begin fails++; $display("FAIL unknown_err: got %0d want 1", err_count); end
        tests++; if (n_tx - tx0 !== 1 || last_tx !== {8'h41, 1'b0, 32'd9, 32'd200, 32'd3}) begin
            fails++; $display("FAIL unknown_tx: tx=%0d order=%h", n_tx - tx0, last_tx); end
    endtask

    task automatic test_early_last();
        int tx0 = n_tx;
        build_frame(8'h41, 8'h42, 32'd5, 32'd50, 32'd1);
        send_frame(9, 10, 0);
        repeat (3) @(posedge clk); #1;
        tests++; if (err_count !== 4'd2) begin fails++; $display("FAIL early_err: got %0d want 2", err_count); end
        tests++; if (n_tx - tx0 !== 0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL early_no_out: tx=%0d valid=%b want 0,0", n_tx - tx0, out_valid); end
        build_frame(8'h55, 8'h53, 32'h11223344, 32'h0A0B0C0D, 32'd5);
        send_frame(13, 14, 0);
        tests++; if (out_valid !== 1'b1 || out_order !== {8'h55, 1'b0, 32'h11223344, 32'h0A0B0C0D, 32'd5}) begin
            fails++; $display("FAIL early_next: valid=%b order=%h", out_valid, out_order); end
        @(posedge clk); #1;
    endtask

    task automatic test_missing_last();
        int tx0 = n_tx;
        build_frame(8'h41, 8'h42, 32'd1, 32'd2, 32'd3);
        send_frame(-1, 14, 0);
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h00, 1'b1);
        @(posedge clk); #1;
        tests++; if (err_count !== 4'd3) begin fails++; $display("FAIL missing_err: got %0d want 3", err_count); end
        tests++; if (n_tx - tx0 !== 0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL missing_no_out: tx=%0d valid=%b want 0,0", n_tx - tx0, out_valid); end
        build_frame(8'h44, 8'h42, 32'hCAFEF00D, 32'd0, 32'd0);
        send_frame(5, 6, 0);
        tests++; if (out_valid !== 1'b1 || out_order !== {8'h44, 1'b1, 32'hCAFEF00D, 32'd0, 32'd0}) begin
            fails++; $display("FAIL missing_next: valid=%b order=%h", out_valid, out_order); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int tx0 = n_tx;
        bit bad = 0;
        out_ready = 1'b0;
        build_frame(8'h55, 8'h42, 32'hDEADBEEF, 32'd1234, 32'd77);
        send_frame(13, 14, 0);
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_order !== {8'h55, 1'b1, 32'hDEADBEEF, 32'd1234, 32'd77})
                bad = 1;
            @(posedge clk); #1;
        end
        tests++; if (bad || n_tx - tx0 !== 0) begin
            fails++; $display("FAIL bp_hold: unstable=%0d tx=%0d want 0,0", bad, n_tx - tx0); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (n_tx - tx0 !== 1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release: tx=%0d valid=%b ready=%b want 1,0,1", n_tx - tx0, out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int tx0 = n_tx;
        build_frame(8'h55, 8'h53, 32'd42, 32'd99, 32'd8);
        send_frame(-1, 7, 0);
        reset_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_order !== 105'd0 || err_count !== 4'd0) begin
            fails++; $display("FAIL rst_mid_outputs: valid=%b order=%h err=%0d want all 0", out_valid, out_order, err_count); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1 || n_tx - tx0 !== 0) begin
            fails++; $display("FAIL rst_mid_state: ready=%b tx=%0d want 1,0", in_ready, n_tx - tx0); end
        build_frame(8'h41, 8'h42, 32'd3, 32'd30, 32'd300);
        send_frame(13, 14, 0);
        @(posedge clk); #1;
        tests++; if (n_tx - tx0 !== 1 || last_tx !== {8'h41, 1'b1, 32'd3, 32'd30, 32'd300}) begin
            fails++; $display("FAIL rst_mid_next: tx=%0d order=%h", n_tx - tx0, last_tx); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) send_byte(8'h5A, 1'b1);
        tests++; if (err_count !== 4'hF) begin fails++; $display("FAIL err_saturate: got %0d want 15", err_count); end
    endtask

    initial begin
        reset_n = 1'b1;
        test_reset();
        test_add();
        test_delete_gapped();
        test_unknown_type();
        test_early_last();
        test_missing_last();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
